pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central sequencer for the 5-stage RV32 core. Drives pc_en plus en/sync_rst of IF_ID, ID_EX,
//  EX_MEM and MEM_WB. Handles boot flush, load-use stall, EX redirect flush, data-memory wait
//  freeze, and halt/resume. Keeps saturating perf counters. Top level instantiates one copy;
//  its outputs replace the constant en=1 / sync_rst=0 tie-offs.
// PARAMETERS
//  BOOT_FLUSH_CYC  4    cycles of full-pipe flush after reset release (>=1)
//  MEM_TIMEOUT     255  max consecutive mem-wait cycles before fault (0 = never)
//  CNT_W           32   width of perf counters
// PORTS
//  clk             in   1      clock, rising edge
//  async_rst_n     in   1      asynchronous, active-low reset
//  id_rs1/id_rs2   in   5      source regs of instr in ID
//  id_rs1_used     in   1      ID instr reads rs1 (same for id_rs2_used)
//  ex_rd           in   5      dest reg of instr in EX
//  ex_is_load      in   1      EX instr is a load
//  ex_redirect     in   1      EX resolved taken branch/jump (PC redirect)
//  mem_req         in   1      MEM stage has an access in flight
//  mem_ready       in   1      data memory completes access this cycle
//  wb_halt         in   1      ecall/halt instr retiring in WB
//  resume          in   1      single-cycle pulse: leave HALTED
//  pc_en           out  1      PC register update enable
//  IF_ID_en/IF_ID_sync_rst, ID_EX_en/_sync_rst, EX_MEM_en/_sync_rst, MEM_WB_en/_sync_rst  out 1 each
//  halted          out  1      core stopped
//  mem_fault       out  1      sticky: MEM_TIMEOUT exceeded
//  stall_cnt       out  CNT_W  cycles with pc_en=0 in RUN (saturating)
//  flush_cnt       out  CNT_W  redirect flushes taken (saturating)
// BEHAVIOUR
//  States: BOOT, RUN, MEM_WAIT, HALTED. Registered state; control outputs combinational from state+inputs.
//  Reset (async): state=BOOT, boot_cnt=0, wait_cnt=0, counters=0, mem_fault=0.
//   Outputs while in reset: pc_en=0, all en=1, all sync_rst=1, halted=0.
//  BOOT: all sync_rst=1, en=1, pc_en=0. boot_cnt increments; at BOOT_FLUSH_CYC-1 -> RUN.
//  Rule: whenever a sync_rst is 1, the matching en is also 1.
//  RUN, priority high->low. Default: all en=1, sync_rst=0, pc_en=1.
//   1 mem_wait = mem_req & ~mem_ready: all en=0, pc_en=0 -> MEM_WAIT; wait_cnt=1.
//   2 wb_halt: MEM_WB_en=1, others en=0, pc_en=0 -> HALTED.
//   3 ex_redirect: IF_ID_sync_rst=1, ID_EX_sync_rst=1, pc_en=1; flush_cnt++.
//     Redirect overrides load-use: the ID instr is squashed anyway.
//   4 load_use = ex_is_load & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)):
//     pc_en=0, IF_ID_en=0, ID_EX_sync_rst=1 (bubble). EX_MEM and MEM_WB advance. Exactly 1 stall cycle.
//  MEM_WAIT: all en=0, pc_en=0, wait_cnt++.
//   On mem_ready: outputs as RUN with priority 1 skipped; evaluate rules 2-4 that cycle; -> RUN.
//   A frozen ex_redirect/load_use stays asserted and is applied on the exit cycle, never lost.
//   If wait_cnt==MEM_TIMEOUT and MEM_TIMEOUT!=0: mem_fault<=1, -> HALTED.
//  HALTED: halted=1, all en=0, sync_rst=0, pc_en=0.
//   resume & ~mem_fault -> RUN next cycle. resume with mem_fault=1 is ignored.
//  stall_cnt increments every cycle in RUN/MEM_WAIT with pc_en=0. Not counted in BOOT/HALTED.
//  Both counters saturate at all-ones and do not wrap.
//  Simultaneous wb_halt+mem_wait: mem_wait wins; halt is taken on the exit cycle.
//  Reset mid-operation: immediate return to BOOT, counters cleared.
// STRUCTURE
//  include/PipelineCtrlDefs.vh: state encodings (BOOT=0,RUN=1,MEM_WAIT=2,HALTED=3) and x0 constant.
//  One sub-module: sat_counter #(W) (clk, async_rst_n, inc, q); instantiated for stall_cnt and flush_cnt.
//  Hazard compare and priority mux are inline.
// TESTING
//  Reset release -> 4 cycles all sync_rst=1, pc_en=0; cycle 5 RUN, all en=1, pc_en=1.
//  lw x5 in EX, ID reads x5 as rs2 -> 1 cycle pc_en=0, IF_ID_en=0, ID_EX_sync_rst=1; stall_cnt=1.
//   Same case with ex_rd=0 -> no stall.
//  ex_redirect=1 and load_use=1 same cycle -> pc_en=1, IF_ID/ID_EX sync_rst=1, flush_cnt=1, stall_cnt=0.
//  mem_req=1, mem_ready low 3 cycles (redirect held) -> 3 frozen cycles, then exit cycle performs flush.
//   With MEM_TIMEOUT=2 -> mem_fault=1, halted=1, resume ignored.
//  wb_halt pulse -> halted=1 next cycle, pc_en=0; resume pulse -> RUN.
//   async_rst_n low in MEM_WAIT -> BOOT immediately, counters=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/sequencing controller.
//   ctrl_state_e  : sequencer states (BOOT=0, RUN=1, MEM_WAIT=2, HALTED=3)
//   REG_X0        : architectural zero register index (never a hazard source)
//   stage_ctrl_t  : en/sync_rst pair for one pipeline register
//   loadUseHazard : ID-stage dependency on a load currently in EX
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } ctrl_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic en;
    logic syncRst;
  } stage_ctrl_t;

  // A flushing stage must also be enabled so the clear actually lands.
  localparam stage_ctrl_t STAGE_HOLD  = '{en: 1'b0, syncRst: 1'b0};
  localparam stage_ctrl_t STAGE_RUN   = '{en: 1'b1, syncRst: 1'b0};
  localparam stage_ctrl_t STAGE_FLUSH = '{en: 1'b1, syncRst: 1'b1};

  // Writes to x0 are discarded, so a load targeting x0 never creates a dependency.
  function automatic logic loadUseHazard(
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       rs1Used,
    input logic       rs2Used,
    input logic [4:0] exRd,
    input logic       exIsLoad
  );
    return exIsLoad && (exRd != REG_X0) &&
           ((rs1Used && (rs1 == exRd)) || (rs2Used && (rs2 == exRd)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the hazard controller and the rest of the RV32 core.
//   master : controller side (consumes hazard info, drives enables/flushes/status)
//   slave  : core side (drives hazard info, consumes enables/flushes/status)
// Inputs to the controller : id_rs1/id_rs2 (+_used), ex_rd, ex_is_load, ex_redirect,
//                            mem_req, mem_ready, wb_halt, resume
// Outputs of the controller: pc_en, <stage>_en/<stage>_sync_rst for IF_ID, ID_EX,
//                            EX_MEM, MEM_WB, halted, mem_fault, stall_cnt, flush_cnt
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ready;
  logic             wb_halt;
  logic             resume;

  logic             pc_en;
  logic             IF_ID_en;
  logic             IF_ID_sync_rst;
  logic             ID_EX_en;
  logic             ID_EX_sync_rst;
  logic             EX_MEM_en;
  logic             EX_MEM_sync_rst;
  logic             MEM_WB_en;
  logic             MEM_WB_sync_rst;
  logic             halted;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_is_load,
           ex_redirect, mem_req, mem_ready, wb_halt, resume,
    output pc_en, IF_ID_en, IF_ID_sync_rst, ID_EX_en, ID_EX_sync_rst,
           EX_MEM_en, EX_MEM_sync_rst, MEM_WB_en, MEM_WB_sync_rst,
           halted, mem_fault, stall_cnt, flush_cnt
  );

  modport slave (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_is_load,
           ex_redirect, mem_req, mem_ready, wb_halt, resume,
    input  pc_en, IF_ID_en, IF_ID_sync_rst, ID_EX_en, ID_EX_sync_rst,
           EX_MEM_en, EX_MEM_sync_rst, MEM_WB_en, MEM_WB_sync_rst,
           halted, mem_fault, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the performance counters.
//   clk         : clock, rising edge
//   async_rst_n : asynchronous active-low reset, clears the count
//   inc         : count this cycle
//   q           : current count, sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         async_rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Counter register: holds once every bit is set instead of wrapping to zero.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the 5-stage RV32 core: drives pc_en and the en/sync_rst pairs
// of IF_ID, ID_EX, EX_MEM and MEM_WB. Handles boot flush, load-use stall, EX redirect
// flush, data-memory wait freeze and halt/resume, and keeps saturating perf counters.
//   clk         : clock, rising edge
//   async_rst_n : asynchronous active-low reset (returns to BOOT, clears counters)
//   ctrl_if     : master modport carrying hazard inputs and all control/status outputs
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int BOOT_FLUSH_CYC = 4,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_W          = 32
) (
  input  logic                   clk,
  input  logic                   async_rst_n,
  pipeline_hazard_ctrl_if.master ctrl_if
);

  localparam int                BOOT_W     = (BOOT_FLUSH_CYC > 1) ? $clog2(BOOT_FLUSH_CYC) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST  = BOOT_W'(BOOT_FLUSH_CYC - 1);
  localparam int                WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;

  ctrl_state_e       state_q, state_d;
  logic [BOOT_W-1:0] bootCnt_q, bootCnt_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic              memFault_q, memFault_d;

  logic        memBlocked;
  logic        loadUse;
  logic        issue;
  stage_ctrl_t ifId, idEx, exMem, memWb;
  logic        pcEn;
  logic        haltedOut;
  logic        stallInc;
  logic        flushInc;

  assign memBlocked = ctrl_if.mem_req & ~ctrl_if.mem_ready;
  assign loadUse    = loadUseHazard(ctrl_if.id_rs1, ctrl_if.id_rs2, ctrl_if.id_rs1_used,
                                    ctrl_if.id_rs2_used, ctrl_if.ex_rd, ctrl_if.ex_is_load);

  // The pipeline may act on halt/redirect/load-use this cycle: a RUN cycle not blocked by
  // memory, or the MEM_WAIT cycle in which the access finally completes. Hazard inputs are
  // frozen with the pipe during the wait, so they are applied on that exit cycle.
  assign issue = (state_q == RUN) ? ~memBlocked
                                  : ((state_q == MEM_WAIT) && ctrl_if.mem_ready);

  // State register plus boot/wait counters and the sticky fault flag.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q    <= BOOT;
      bootCnt_q  <= '0;
      waitCnt_q  <= '0;
      memFault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bootCnt_q  <= bootCnt_d;
      waitCnt_q  <= waitCnt_d;
      memFault_q <= memFault_d;
    end
  end

  // Next-state logic. A stalled memory access has top priority; a halt arriving during
  // the wait is taken on the exit cycle. The timeout check only fires while still waiting.
  always_comb begin
    state_d    = state_q;
    bootCnt_d  = bootCnt_q;
    waitCnt_d  = waitCnt_q;
    memFault_d = memFault_q;
    unique case (state_q)
      BOOT: begin
        bootCnt_d = bootCnt_q + BOOT_W'(1);
        if (bootCnt_q == BOOT_LAST) state_d = RUN;
      end
      RUN: begin
        if (memBlocked) begin
          state_d   = MEM_WAIT;
          waitCnt_d = WAIT_W'(1);
        end else if (ctrl_if.wb_halt) begin
          state_d = HALTED;
        end
      end
      MEM_WAIT: begin
        if (ctrl_if.mem_ready) begin
          state_d = ctrl_if.wb_halt ? HALTED : RUN;
        end else if ((MEM_TIMEOUT != 0) && (waitCnt_q == WAIT_LIMIT)) begin
          memFault_d = 1'b1;
          state_d    = HALTED;
        end else if (waitCnt_q != WAIT_MAX) begin
          waitCnt_d = waitCnt_q + WAIT_W'(1);
        end
      end
      HALTED: begin
        if (ctrl_if.resume && !memFault_q) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  // Output logic. Everything holds by default; each issuing rule then opens up only the
  // stages it needs. A redirect squashes the ID instruction, so it outranks load-use.
  always_comb begin
    pcEn      = 1'b0;
    ifId      = STAGE_HOLD;
    idEx      = STAGE_HOLD;
    exMem     = STAGE_HOLD;
    memWb     = STAGE_HOLD;
    haltedOut = 1'b0;
    stallInc  = 1'b0;
    flushInc  = 1'b0;
    unique case (state_q)
      BOOT: begin
        ifId  = STAGE_FLUSH;
        idEx  = STAGE_FLUSH;
        exMem = STAGE_FLUSH;
        memWb = STAGE_FLUSH;
      end
      RUN, MEM_WAIT: begin
        if (issue) begin
          if (ctrl_if.wb_halt) begin
            memWb = STAGE_RUN;
          end else if (ctrl_if.ex_redirect) begin
            pcEn     = 1'b1;
            ifId     = STAGE_FLUSH;
            idEx     = STAGE_FLUSH;
            exMem    = STAGE_RUN;
            memWb    = STAGE_RUN;
            flushInc = 1'b1;
          end else if (loadUse) begin
            idEx  = STAGE_FLUSH;
            exMem = STAGE_RUN;
            memWb = STAGE_RUN;
          end else begin
            pcEn  = 1'b1;
            ifId  = STAGE_RUN;
            idEx  = STAGE_RUN;
            exMem = STAGE_RUN;
            memWb = STAGE_RUN;
          end
        end
        stallInc = ~pcEn;
      end
      HALTED: haltedOut = 1'b1;
      default: ;
    endcase
  end

  assign ctrl_if.pc_en           = pcEn;
  assign ctrl_if.IF_ID_en        = ifId.en;
  assign ctrl_if.IF_ID_sync_rst  = ifId.syncRst;
  assign ctrl_if.ID_EX_en        = idEx.en;
  assign ctrl_if.ID_EX_sync_rst  = idEx.syncRst;
  assign ctrl_if.EX_MEM_en       = exMem.en;
  assign ctrl_if.EX_MEM_sync_rst = exMem.syncRst;
  assign ctrl_if.MEM_WB_en       = memWb.en;
  assign ctrl_if.MEM_WB_sync_rst = memWb.syncRst;
  assign ctrl_if.halted          = haltedOut;
  assign ctrl_if.mem_fault       = memFault_q;

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .inc         (stallInc),
    .q           (ctrl_if.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flushCnt (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .inc         (flushInc),
    .q           (ctrl_if.flush_cnt)
  );

endmodule
